// File: rtl/lstm_delta_pkg.sv
// ============================================================================
// Module   : lstm_delta_pkg
// Purpose  : Fixed-point format, saturation bounds and stage records for lstm_delta.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lstm_delta_pkg;

    localparam int DWIDTH = 16;
    localparam int NBIT   = 8;

    typedef logic signed [DWIDTH-1:0] data_t;

    localparam data_t ONE  = data_t'(1 << NBIT);
    localparam data_t DMAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam data_t DMIN = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef struct packed {
        data_t m1;
        data_t m2;
        data_t m3;
        data_t gi;
        data_t gf;
        data_t go;
        data_t m4;
        data_t f;
        data_t i;
        data_t a;
        data_t c_prev;
        data_t dc_next;
        logic  last;
    } stage1_t;

    typedef struct packed {
        data_t dc;
        data_t do_v;
        data_t ca;
        data_t cc;
        data_t ia;
        data_t f;
        logic  last;
    } stage2_t;

    // Overflow shows up as disagreement between the two top bits of the widened sum.
    function automatic data_t sat_add(input data_t x, input data_t y);
        logic signed [DWIDTH:0] s;
        s = {x[DWIDTH-1], x} + {y[DWIDTH-1], y};
        if (s[DWIDTH] != s[DWIDTH-1]) return s[DWIDTH] ? DMIN : DMAX;
        return s[DWIDTH-1:0];
    endfunction

    function automatic data_t sat_sub(input data_t x, input data_t y);
        logic signed [DWIDTH:0] s;
        s = {x[DWIDTH-1], x} - {y[DWIDTH-1], y};
        if (s[DWIDTH] != s[DWIDTH-1]) return s[DWIDTH] ? DMIN : DMAX;
        return s[DWIDTH-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/lstm_delta_fxmul.sv
// ============================================================================
// Module   : lstm_delta_fxmul
// Purpose  : Signed fixed-point multiply, floor shift by NBIT, saturate to DWIDTH.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lstm_delta_fxmul
    import lstm_delta_pkg::*;
(
    input  logic signed [DWIDTH-1:0] x,
    input  logic signed [DWIDTH-1:0] y,
    output logic signed [DWIDTH-1:0] p
);

    logic signed [2*DWIDTH-1:0] full;
    logic signed [2*DWIDTH-1:0] shifted;

    always_comb begin
        full    = (2*DWIDTH)'(x) * (2*DWIDTH)'(y);
        shifted = full >>> NBIT;
        // Result fits only if every bit above the target sign bit copies it.
        if (shifted[2*DWIDTH-1:DWIDTH-1] == '0 || shifted[2*DWIDTH-1:DWIDTH-1] == '1)
            p = shifted[DWIDTH-1:0];
        else
            p = shifted[2*DWIDTH-1] ? DMIN : DMAX;
    end

endmodule

`default_nettype wire

// File: rtl/lstm_delta.sv
// ============================================================================
// Module   : lstm_delta
// Purpose  : LSTM backward-pass element engine, 3-stage global-enable pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lstm_delta
    import lstm_delta_pkg::*;
(
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic signed [DWIDTH-1:0] i,
    input  logic signed [DWIDTH-1:0] f,
    input  logic signed [DWIDTH-1:0] o,
    input  logic signed [DWIDTH-1:0] a,
    input  logic signed [DWIDTH-1:0] tanh_c,
    input  logic signed [DWIDTH-1:0] c_prev,
    input  logic signed [DWIDTH-1:0] dh,
    input  logic signed [DWIDTH-1:0] dc_next,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic signed [DWIDTH-1:0] di,
    output logic signed [DWIDTH-1:0] df,
    output logic signed [DWIDTH-1:0] do_,
    output logic signed [DWIDTH-1:0] da,
    output logic signed [DWIDTH-1:0] dc_prev
);

    logic    stall;
    logic    advance;
    logic    v1;
    logic    v2;
    stage1_t s1;
    stage2_t s2;

    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = !stall;

    // Stage 1 arithmetic
    data_t one_m_i, one_m_f, one_m_o;
    data_t m1_n, m2_n, m3_n, gi_n, gf_n, go_n, m4_n;

    assign one_m_i = sat_sub(ONE, i);
    assign one_m_f = sat_sub(ONE, f);
    assign one_m_o = sat_sub(ONE, o);

    lstm_delta_fxmul u_m1 (.x(dh),     .y(o),       .p(m1_n));
    lstm_delta_fxmul u_m2 (.x(dh),     .y(tanh_c),  .p(m2_n));
    lstm_delta_fxmul u_m3 (.x(tanh_c), .y(tanh_c),  .p(m3_n));
    lstm_delta_fxmul u_gi (.x(i),      .y(one_m_i), .p(gi_n));
    lstm_delta_fxmul u_gf (.x(f),      .y(one_m_f), .p(gf_n));
    lstm_delta_fxmul u_go (.x(o),      .y(one_m_o), .p(go_n));
    lstm_delta_fxmul u_m4 (.x(a),      .y(a),       .p(m4_n));

    // Stage 2 arithmetic
    data_t one_m_m3, one_m_m4;
    data_t dcm_n, dc_n, do_n, ca_n, cc_n, ia_n;

    assign one_m_m3 = sat_sub(ONE, s1.m3);
    assign one_m_m4 = sat_sub(ONE, s1.m4);
    assign dc_n     = sat_add(dcm_n, s1.dc_next);

    lstm_delta_fxmul u_dc (.x(s1.m1),     .y(one_m_m3), .p(dcm_n));
    lstm_delta_fxmul u_do (.x(s1.m2),     .y(s1.go),    .p(do_n));
    lstm_delta_fxmul u_ca (.x(s1.a),      .y(s1.gi),    .p(ca_n));
    lstm_delta_fxmul u_cc (.x(s1.c_prev), .y(s1.gf),    .p(cc_n));
    lstm_delta_fxmul u_ia (.x(s1.i),      .y(one_m_m4), .p(ia_n));

    // Stage 3 arithmetic
    data_t di_n, df_n, da_n, dcp_n;

    lstm_delta_fxmul u_di  (.x(s2.dc), .y(s2.ca), .p(di_n));
    lstm_delta_fxmul u_df  (.x(s2.dc), .y(s2.cc), .p(df_n));
    lstm_delta_fxmul u_da  (.x(s2.dc), .y(s2.ia), .p(da_n));
    lstm_delta_fxmul u_dcp (.x(s2.dc), .y(s2.f),  .p(dcp_n));

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            s1        <= '0;
            s2        <= '0;
            out_last  <= 1'b0;
            di        <= '0;
            df        <= '0;
            do_       <= '0;
            da        <= '0;
            dc_prev   <= '0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;

            s1.m1      <= m1_n;
            s1.m2      <= m2_n;
            s1.m3      <= m3_n;
            s1.gi      <= gi_n;
            s1.gf      <= gf_n;
            s1.go      <= go_n;
            s1.m4      <= m4_n;
            s1.f       <= f;
            s1.i       <= i;
            s1.a       <= a;
            s1.c_prev  <= c_prev;
            s1.dc_next <= dc_next;
            s1.last    <= in_last;

            s2.dc   <= dc_n;
            s2.do_v <= do_n;
            s2.ca   <= ca_n;
            s2.cc   <= cc_n;
            s2.ia   <= ia_n;
            s2.f    <= s1.f;
            s2.last <= s1.last;

            out_last <= s2.last;
            di       <= di_n;
            df       <= df_n;
            da       <= da_n;
            do_      <= s2.do_v;
            dc_prev  <= dcp_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lstm_delta.sv
// ============================================================================
// Module   : tb_lstm_delta
// Purpose  : Self-checking bench for lstm_delta (directed vectors plus scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lstm_delta;

    logic clk = 1'b0;
    logic xrst;
    logic in_valid;
    logic in_ready;
    logic in_last;
    logic out_valid;
    logic out_ready;
    logic out_last;
    logic signed [15:0] i, f, o, a, tanh_c, c_prev, dh, dc_next;
    logic signed [15:0] di, df, do_, da, dc_prev;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int rdy_mode = 0;
    int rcnt = 0;
    logic [80:0] exp_q[$];

    lstm_delta dut (
        .clk(clk), .xrst(xrst),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .i(i), .f(f), .o(o), .a(a), .tanh_c(tanh_c), .c_prev(c_prev),
        .dh(dh), .dc_next(dc_next),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .di(di), .df(df), .do_(do_), .da(da), .dc_prev(dc_prev)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [80:0] got, input logic [80:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic int clamp16(longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int fx(int x, int y);
        longint p;
        p = longint'(x) * longint'(y);
        p = p >>> 8;
        return clamp16(p);
    endfunction

    function automatic int sat(int s);
        return clamp16(longint'(s));
    endfunction

    function automatic logic [80:0] model(int vi, int vf, int vo, int va, int vt,
                                          int vcp, int vdh, int vdcn, bit vl);
        int m1, m2, m3, gi, gf, go, m4, dc, dov, ca, cc, ia;
        m1  = fx(vdh, vo);
        m2  = fx(vdh, vt);
        m3  = fx(vt, vt);
        gi  = fx(vi, sat(256 - vi));
        gf  = fx(vf, sat(256 - vf));
        go  = fx(vo, sat(256 - vo));
        m4  = fx(va, va);
        dc  = sat(fx(m1, sat(256 - m3)) + vdcn);
        dov = fx(m2, go);
        ca  = fx(va, gi);
        cc  = fx(vcp, gf);
        ia  = fx(vi, sat(256 - m4));
        return {vl, 16'(fx(dc, ca)), 16'(fx(dc, cc)), 16'(fx(dc, ia)), 16'(dov), 16'(fx(dc, vf))};
    endfunction

    function automatic int rv();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 512)) - 256;
    endfunction

    // Scoreboard: accepts and consumptions are decided by mid-cycle values.
    always @(negedge clk) begin
        if (xrst) begin
            if (in_valid && in_ready)
                exp_q.push_back(model(i, f, o, a, tanh_c, c_prev, dh, dc_next, in_last));
            if (rdy_mode == 1)
                check_eq("in_ready_rule", 81'(in_ready), 81'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check_eq("unexpected_beat", 81'(1), 81'(0));
                else check_eq("stream", {out_last, di, df, da, do_, dc_prev}, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (rcnt % 3 == 0); rcnt++; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic send(input int vi, input int vf, input int vo, input int va, input int vt,
                        input int vcp, input int vdh, input int vdcn, input bit vl);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        i = 16'(vi); f = 16'(vf); o = 16'(vo); a = 16'(va);
        tanh_c = 16'(vt); c_prev = 16'(vcp); dh = 16'(vdh); dc_next = 16'(vdcn);
        in_last = vl;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check_eq("accept_timeout", 81'(0), 81'(1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Expects out_ready held high; checks latency and the hand-computed outputs.
    task automatic run_dir(input string tag, input int vi, input int vf, input int vo, input int va,
                           input int vt, input int vcp, input int vdh, input int vdcn,
                           input logic [79:0] exp);
        int lat;
        lat = 0;
        send(vi, vf, vo, va, vt, vcp, vdh, vdcn, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        check_eq({tag, "_latency"}, 81'(lat), 81'(3));
        check_eq(tag, {1'b0, di, df, da, do_, dc_prev}, {1'b0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rdy_mode = 0;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check_eq("drain_empty", 81'(exp_q.size()), 81'(0));
    endtask

    initial begin
        int base;
        xrst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        i = '0; f = '0; o = '0; a = '0; tanh_c = '0; c_prev = '0; dh = '0; dc_next = '0;
        #12;
        check_eq("reset_outputs", {out_valid, out_last, di, df, da, do_, dc_prev}, 82'(0));
        check_eq("reset_in_ready", 81'(in_ready), 81'(1));
        @(negedge clk);
        xrst = 1'b1;
        @(posedge clk);
        #1;

        // Nominal, saturation and negative-floor vectors
        run_dir("nominal",   128, 128, 128, 128, 0, 256, 256, 0,
                {16'sd16, 16'sd32, 16'sd48, 16'sd0, 16'sd64});
        run_dir("saturate",  0, 256, 256, 0, 0, 0, 32767, 32767,
                {16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd32767});
        run_dir("neg_floor_o256", 0, 256, 256, 0, 0, 0, -1, 0,
                {16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd1});
        run_dir("neg_floor_o1",   0, 256, 1, 0, 0, 0, -1, 0,
                {16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd1});

        // Backpressure with out_ready pattern 1,0,0 repeating
        base = n_out;
        rcnt = 0;
        rdy_mode = 1;
        for (int k = 0; k < 8; k++)
            send(64 + 16 * k, 200 - 8 * k, 100 + k, -50 * k, 30 * k, 300 - 40 * k,
                 500 + 7 * k, -20 * k, k == 7);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check_eq("bp_beats_out", 81'(n_out - base), 81'(8));
        drain();

        // Asynchronous reset with three beats held in the pipeline
        rdy_mode = 3;
        @(posedge clk);
        #1;
        send(100, 100, 100, 100, 100, 100, 100, 100, 1'b1);
        send(-90, 50, 20, 10, -30, 40, 500, 60, 1'b1);
        send(30, 30, 30, 30, 30, 30, 30, 30, 1'b1);
        #2;
        xrst = 1'b0;
        #1;
        check_eq("rst_mid_outputs", {out_valid, out_last, di, df, da, do_, dc_prev}, 82'(0));
        check_eq("rst_mid_in_ready", 81'(in_ready), 81'(1));
        exp_q.delete();
        rdy_mode = 0;
        @(negedge clk);
        xrst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check_eq("rst_discarded", 81'(out_valid), 81'(0));
        end
        run_dir("after_reset", 128, 128, 128, 128, 0, 256, 256, 0,
                {16'sd16, 16'sd32, 16'sd48, 16'sd0, 16'sd64});

        // Randomised stream with random out_ready
        base = n_out;
        rdy_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rv(), rv(), rv(), rv(), rv(), rv(), rv(), rv(), 1'($urandom_range(0, 1)));
        end
        drain();
        check_eq("rand_beats_out", 81'(n_out - base), 81'(1000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
